// File: rtl/rr_pkg.sv
// Shared types and the writeback-bypass read helper for the register-read stage.
package rr_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 64;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef logic [IDX_W-1:0]  reg_idx_t;
  typedef logic [DATA_W-1:0] reg_val_t;

  // A writeback committing this cycle is newer than the register file copy.
  function automatic reg_val_t rr_bypass(input reg_idx_t                   idx,
                                         input logic [NUM_REGS*DATA_W-1:0] rf,
                                         input logic                       wb_valid,
                                         input reg_idx_t                   wb_idx,
                                         input reg_val_t                   wb_data);
    if (wb_valid && (wb_idx == idx)) return wb_data;
    return rf[int'(idx)*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/rr_scoreboard.sv
// Per-register busy vector for in-flight destinations, with hazard lookup per read port.
module rr_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int NUM_LK   = 3,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    set_en,
  input  logic [IDX_W-1:0]        set_idx,
  input  logic                    clr_en,
  input  logic [IDX_W-1:0]        clr_idx,
  input  logic                    fclr_en,
  input  logic [IDX_W-1:0]        fclr_idx,
  input  logic [NUM_LK*IDX_W-1:0] lk_idx,
  input  logic [NUM_LK-1:0]       lk_vld,
  output logic [NUM_LK-1:0]       hit,
  output logic [NUM_REGS-1:0]     busy
);

  logic [NUM_REGS-1:0] busy_nxt;
  logic [IDX_W-1:0]    idx;

  // Clears are applied first so a same-cycle set on the same index wins.
  always_comb begin
    busy_nxt = busy;
    if (clr_en)  busy_nxt[clr_idx]  = 1'b0;
    if (fclr_en) busy_nxt[fclr_idx] = 1'b0;
    if (set_en)  busy_nxt[set_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy <= '0;
    else          busy <= busy_nxt;
  end

  // A register being written back this cycle is forwarded, so it is not a hazard.
  always_comb begin
    hit = '0;
    idx = '0;
    for (int p = 0; p < NUM_LK; p++) begin
      idx    = lk_idx[p*IDX_W +: IDX_W];
      hit[p] = lk_vld[p] && busy[idx] && !(clr_en && (clr_idx == idx));
    end
  end

endmodule

// File: rtl/reg_read_stage.sv
// Register-read stage: operand fetch with writeback bypass, RAW/WAW stall, one-entry output register.
module reg_read_stage
  import rr_pkg::*;
#(
  parameter int NUM_REGS  = rr_pkg::NUM_REGS,
  parameter int DATA_W    = rr_pkg::DATA_W,
  parameter int NUM_SRC   = 2,
  parameter int PAYLOAD_W = 512,
  parameter int CNT_W     = 32,
  parameter int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_SRC*IDX_W-1:0]   in_src_idx,
  input  logic [NUM_SRC-1:0]         in_src_vld,
  input  logic [IDX_W-1:0]           in_dst_idx,
  input  logic                       in_dst_vld,
  input  logic [PAYLOAD_W-1:0]       in_payload,
  input  logic [NUM_REGS*DATA_W-1:0] rf_rdata,
  input  logic                       wb_valid,
  input  logic [IDX_W-1:0]           wb_idx,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_SRC*DATA_W-1:0]  out_opnd,
  output logic [NUM_SRC-1:0]         out_opnd_vld,
  output logic [NUM_SRC*IDX_W-1:0]   out_src_idx,
  output logic [IDX_W-1:0]           out_dst_idx,
  output logic                       out_dst_vld,
  output logic [DATA_W-1:0]          out_dst_old,
  output logic [PAYLOAD_W-1:0]       out_payload,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int NUM_LK = NUM_SRC + 1;

  logic [NUM_LK-1:0]         hit;
  logic [NUM_REGS-1:0]       busy;
  logic                      hazard;
  logic                      accept;
  logic [NUM_SRC*DATA_W-1:0] opnd_nxt;
  logic [DATA_W-1:0]         dst_old_nxt;
  logic [IDX_W-1:0]          sidx;

  // Lookup port NUM_SRC is the destination, catching WAW on an in-flight write.
  rr_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_LK   (NUM_LK),
    .IDX_W    (IDX_W)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en   (accept && in_dst_vld),
    .set_idx  (in_dst_idx),
    .clr_en   (wb_valid),
    .clr_idx  (wb_idx),
    .fclr_en  (flush && out_valid && out_dst_vld),
    .fclr_idx (out_dst_idx),
    .lk_idx   ({in_dst_idx, in_src_idx}),
    .lk_vld   ({in_dst_vld, in_src_vld}),
    .hit      (hit),
    .busy     (busy)
  );

  assign hazard   = |hit;
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    opnd_nxt = '0;
    sidx     = '0;
    for (int p = 0; p < NUM_SRC; p++) begin
      sidx = in_src_idx[p*IDX_W +: IDX_W];
      if (in_src_vld[p])
        opnd_nxt[p*DATA_W +: DATA_W] = rr_bypass(sidx, rf_rdata, wb_valid, wb_idx, wb_data);
    end
    dst_old_nxt = in_dst_vld ? rr_bypass(in_dst_idx, rf_rdata, wb_valid, wb_idx, wb_data) : '0;
  end

  // Valid/ready: an entry moves only when valid and ready are both high on a clock edge;
  // the held entry's fields stay stable while out_valid=1 and out_ready=0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_opnd     <= '0;
      out_opnd_vld <= '0;
      out_src_idx  <= '0;
      out_dst_idx  <= '0;
      out_dst_vld  <= 1'b0;
      out_dst_old  <= '0;
      out_payload  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_opnd     <= opnd_nxt;
      out_opnd_vld <= in_src_vld;
      out_src_idx  <= in_src_idx;
      out_dst_idx  <= in_dst_idx;
      out_dst_vld  <= in_dst_vld;
      out_dst_old  <= dst_old_nxt;
      out_payload  <= in_payload;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (in_valid && hazard && !flush && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage (CNT_W=4 build so the stall counter saturation is reachable).
module tb_reg_read_stage;

  localparam int NUM_REGS  = 16;
  localparam int DATA_W    = 64;
  localparam int NUM_SRC   = 2;
  localparam int PAYLOAD_W = 512;
  localparam int CNT_W     = 4;
  localparam int IDX_W     = 4;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_SRC*IDX_W-1:0]   in_src_idx;
  logic [NUM_SRC-1:0]         in_src_vld;
  logic [IDX_W-1:0]           in_dst_idx;
  logic                       in_dst_vld;
  logic [PAYLOAD_W-1:0]       in_payload;
  logic [NUM_REGS*DATA_W-1:0] rf_rdata;
  logic                       wb_valid;
  logic [IDX_W-1:0]           wb_idx;
  logic [DATA_W-1:0]          wb_data;
  logic                       flush;
  logic                       out_valid;
  logic                       out_ready;
  logic [NUM_SRC*DATA_W-1:0]  out_opnd;
  logic [NUM_SRC-1:0]         out_opnd_vld;
  logic [NUM_SRC*IDX_W-1:0]   out_src_idx;
  logic [IDX_W-1:0]           out_dst_idx;
  logic                       out_dst_vld;
  logic [DATA_W-1:0]          out_dst_old;
  logic [PAYLOAD_W-1:0]       out_payload;
  logic [CNT_W-1:0]           stall_cnt;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  reg_read_stage #(
    .NUM_REGS  (NUM_REGS),
    .DATA_W    (DATA_W),
    .NUM_SRC   (NUM_SRC),
    .PAYLOAD_W (PAYLOAD_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_src_idx   (in_src_idx),
    .in_src_vld   (in_src_vld),
    .in_dst_idx   (in_dst_idx),
    .in_dst_vld   (in_dst_vld),
    .in_payload   (in_payload),
    .rf_rdata     (rf_rdata),
    .wb_valid     (wb_valid),
    .wb_idx       (wb_idx),
    .wb_data      (wb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opnd     (out_opnd),
    .out_opnd_vld (out_opnd_vld),
    .out_src_idx  (out_src_idx),
    .out_dst_idx  (out_dst_idx),
    .out_dst_vld  (out_dst_vld),
    .out_dst_old  (out_dst_old),
    .out_payload  (out_payload),
    .stall_cnt    (stall_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic drive(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] svld, input logic [3:0] d, input logic dvld,
                       input logic [31:0] pl);
    in_valid   = v;
    in_src_idx = {s1, s0};
    in_src_vld = svld;
    in_dst_idx = d;
    in_dst_vld = dvld;
    in_payload = {480'd0, pl};
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_idx    = '0;
    wb_data   = '0;
    for (int i = 0; i < NUM_REGS; i++) rf_rdata[i*DATA_W +: DATA_W] = 64'(i * 'h11);
    drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 32'd0);

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_out_opnd", out_opnd, 0);
    chk("rst_busy", dut.busy, 0);
    chk("rst_in_ready", in_ready, 1);
    step();
    step();
    reset_n = 1'b1;

    // 1: basic accept, src r1/r2, dst r3
    drive(1'b1, 4'd1, 4'd2, 2'b11, 4'd3, 1'b1, 32'hCAFE_0001);
    #1 chk("t1_in_ready", in_ready, 1);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_opnd", out_opnd, {64'h22, 64'h11});
    chk("t1_dst_old", out_dst_old, 64'h33);
    chk("t1_payload", out_payload, 512'hCAFE_0001);
    chk("t1_busy", dut.busy, 16'h0008);

    // 2: RAW on r3 stalls until writeback forwards 0xAB
    drive(1'b1, 4'd3, 4'd0, 2'b01, 4'd4, 1'b1, 32'hCAFE_0002);
    #1 chk("t2_in_ready_stall", in_ready, 0);
    step();
    chk("t2_stall_1", stall_cnt, 1);
    chk("t2_drained", out_valid, 0);
    step();
    chk("t2_stall_2", stall_cnt, 2);
    wb_valid = 1'b1;
    wb_idx   = 4'd3;
    wb_data  = 64'hAB;
    #1 chk("t2_in_ready_wb", in_ready, 1);
    step();
    wb_valid = 1'b0;
    chk("t2_out_valid", out_valid, 1);
    chk("t2_opnd_fwd", out_opnd, {64'h0, 64'hAB});
    chk("t2_dst_old", out_dst_old, 64'h44);
    chk("t2_stall_hold", stall_cnt, 2);
    chk("t2_busy", dut.busy, 16'h0010);

    // 3: backpressure holds the entry, release accepts the waiting one
    out_ready = 1'b0;
    drive(1'b1, 4'd1, 4'd0, 2'b01, 4'd6, 1'b1, 32'hCAFE_0003);
    #1 chk("t3_in_ready_bp", in_ready, 0);
    step();
    chk("t3_hold_valid", out_valid, 1);
    chk("t3_hold_opnd", out_opnd, {64'h0, 64'hAB});
    chk("t3_hold_dst", out_dst_idx, 4);
    chk("t3_stall_nohz", stall_cnt, 2);
    out_ready = 1'b1;
    #1 chk("t3_in_ready_rel", in_ready, 1);
    step();
    chk("t3_opnd", out_opnd, {64'h0, 64'h11});
    chk("t3_dst", out_dst_idx, 6);
    chk("t3_busy", dut.busy, 16'h0050);

    // 4: flush squashes held entry dst r5 and the incoming dst r8
    drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 32'hCAFE_0004);
    step();
    chk("t4_held_dst", out_dst_idx, 5);
    chk("t4_busy_set", dut.busy, 16'h0070);
    drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd8, 1'b1, 32'hCAFE_0005);
    flush = 1'b1;
    #1 chk("t4_in_ready_flush", in_ready, 0);
    step();
    flush = 1'b0;
    chk("t4_out_valid", out_valid, 0);
    chk("t4_busy_clr", dut.busy, 16'h0050);
    chk("t4_dst_kept", out_dst_idx, 5);
    chk("t4_stall", stall_cnt, 2);

    // 5: writeback r7 and accept with dst r7 in the same cycle
    drive(1'b1, 4'd7, 4'd0, 2'b01, 4'd7, 1'b1, 32'hCAFE_0006);
    wb_valid = 1'b1;
    wb_idx   = 4'd7;
    wb_data  = 64'h5A;
    #1 chk("t5_in_ready", in_ready, 1);
    step();
    wb_valid = 1'b0;
    chk("t5_busy_setwin", dut.busy, 16'h00D0);
    chk("t5_dst_old_fwd", out_dst_old, 64'h5A);
    chk("t5_opnd_fwd", out_opnd, {64'h0, 64'h5A});

    // 6: sustained hazard on r6 saturates the 4-bit counter, then async reset
    drive(1'b1, 4'd6, 4'd0, 2'b01, 4'd0, 1'b0, 32'hCAFE_0007);
    #1 chk("t6_in_ready", in_ready, 0);
    for (int i = 0; i < 12; i++) step();
    chk("t6_stall_14", stall_cnt, 4'hE);
    for (int i = 0; i < 8; i++) step();
    chk("t6_stall_sat", stall_cnt, 4'hF);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_stall", stall_cnt, 0);
    chk("t6_rst_opnd", out_opnd, 0);
    chk("t6_rst_dst_old", out_dst_old, 0);
    chk("t6_rst_payload", out_payload, 0);
    chk("t6_rst_busy", dut.busy, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    reset_n  = 1'b1;
    step();

    // report
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
